// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: CPU request/ready handshake to single-cycle word RAM accesses.
// Latency: ready is seen WAIT_STATES+2 edges after the request is taken (1 edge for a bad address).
// Backpressure: one transaction in flight; cpu_req is ignored until the FSM is back in IDLE.
//
// Ports:
//   clock, reset                        - system clock, synchronous active-low reset
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata   - CPU request, held until cpu_ready
//   cpu_ready/cpu_rdata/cpu_err         - one-cycle completion pulse, held read data, error flag
//   mem_address/mem_write_en/           - RAM address, one-cycle write strobe, write data
//   mem_data_out/mem_data_in              and combinational read data
//   read_count/write_count/err_count    - completion statistics
module mem_bus_ctrl #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [16:0] MEM_TOP     = 17'h0007f
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_wr,
  input  logic [15:31] cpu_addr,
  input  logic [0:31]  cpu_wdata,
  output logic         cpu_ready,
  output logic [0:31]  cpu_rdata,
  output logic         cpu_err,
  output logic [15:31] mem_address,
  output logic         mem_write_en,
  output logic [0:31]  mem_data_out,
  input  logic [0:31]  mem_data_in,
  output logic [15:0]  read_count,
  output logic [15:0]  write_count,
  output logic [7:0]   err_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE,
    ST_ERROR
  } state_t;

  // WAIT counts down to zero inclusive, so it lasts WAIT_LOAD+1 = WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          wr_q, wr_d;
  logic [15:31]  mem_address_q, mem_address_d;
  logic [0:31]   mem_data_out_q, mem_data_out_d;
  logic          mem_write_en_q, mem_write_en_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          cpu_err_q, cpu_err_d;
  logic [0:31]   cpu_rdata_q, cpu_rdata_d;
  logic [15:0]   read_count_q, read_count_d;
  logic [15:0]   write_count_q, write_count_d;
  logic [7:0]    err_count_q, err_count_d;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    wr_d           = wr_q;
    mem_address_d  = mem_address_q;
    mem_data_out_d = mem_data_out_q;
    cpu_rdata_d    = cpu_rdata_q;
    read_count_d   = read_count_q;
    write_count_d  = write_count_q;
    err_count_d    = err_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          // Request fields are captured once here; later input changes are ignored.
          mem_address_d  = cpu_addr;
          mem_data_out_d = cpu_wdata;
          wr_d           = cpu_wr;
          if (cpu_addr > MEM_TOP) begin
            state_d = ST_ERROR;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_ACCESS;
          end else begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ST_ACCESS: begin
        if (!wr_q) begin
          cpu_rdata_d = mem_data_in;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Counters wrap naturally at 16'hffff.
        if (wr_q) begin
          write_count_d = write_count_q + 16'd1;
        end else begin
          read_count_d = read_count_q + 16'd1;
        end
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        if (err_count_q != 8'hff) begin
          err_count_d = err_count_q + 8'd1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so each one is a pure decode of
    // the state register: the write strobe covers exactly the ACCESS cycle and the
    // ready/err pulse covers exactly the DONE or ERROR cycle.
    mem_write_en_d = (state_d == ST_ACCESS) && wr_d;
    cpu_ready_d    = (state_d == ST_DONE) || (state_d == ST_ERROR);
    cpu_err_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= 4'd0;
      wr_q           <= 1'b0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      mem_write_en_q <= 1'b0;
      cpu_ready_q    <= 1'b0;
      cpu_err_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      read_count_q   <= 16'd0;
      write_count_q  <= 16'd0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      wr_q           <= wr_d;
      mem_address_q  <= mem_address_d;
      mem_data_out_q <= mem_data_out_d;
      mem_write_en_q <= mem_write_en_d;
      cpu_ready_q    <= cpu_ready_d;
      cpu_err_q      <= cpu_err_d;
      cpu_rdata_q    <= cpu_rdata_d;
      read_count_q   <= read_count_d;
      write_count_q  <= write_count_d;
      err_count_q    <= err_count_d;
    end
  end

  assign cpu_ready    = cpu_ready_q;
  assign cpu_err      = cpu_err_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_write_en = mem_write_en_q;
  assign read_count   = read_count_q;
  assign write_count  = write_count_q;
  assign err_count    = err_count_q;

endmodule
